// File: rtl/cook_timer.sv
// BCD MM:SS countdown timer for the microwave controller.
// Keypad digits shift in from the right while idle. The count runs one second
// per CLKS_PER_SEC cycles while the magnetron latch (mag_on) is high, and it
// freezes when mag_on drops. timer_done goes back to the magnetron control.
//
// Handshake: digit_valid is a one-cycle strobe with no back-pressure. A digit
// is taken only in IDLE, when clearn is high, mag_on is low and digit <= 9.
// In every other case the strobe is dropped.
module cook_timer #(
  parameter int CLKS_PER_SEC = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mag_on,
  input  logic       clearn,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       done_pulse,
  output logic       cooking
);

  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, COOK, PAUSE} state_t;

  // state is kept as a named signal so that checkers can bind to it.
  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [3:0]    mt_nx, mo_nx, st_nx, so_nx;
  logic [3:0]    mt_dec, mo_dec, st_dec, so_dec;
  logic          pulse_nx;
  logic          tick;
  logic          dec_zero;

  assign tick       = (presc == TERM);
  assign timer_done = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign cooking    = (state == COOK);
  assign dec_zero   = (mt_dec == 4'd0) && (mo_dec == 4'd0) &&
                      (st_dec == 4'd0) && (so_dec == 4'd0);

  // BCD decrement of MM:SS by one second. A seconds borrow reloads 59.
  // 0:00 stays at 0:00.
  always_comb begin
    mt_dec = min_tens;
    mo_dec = min_ones;
    st_dec = sec_tens;
    so_dec = sec_ones;
    if (sec_ones != 4'd0) begin
      so_dec = sec_ones - 4'd1;
    end else if (sec_tens != 4'd0) begin
      so_dec = 4'd9;
      st_dec = sec_tens - 4'd1;
    end else if (min_ones != 4'd0) begin
      so_dec = 4'd9;
      st_dec = 4'd5;
      mo_dec = min_ones - 4'd1;
    end else if (min_tens != 4'd0) begin
      so_dec = 4'd9;
      st_dec = 4'd5;
      mo_dec = 4'd9;
      mt_dec = min_tens - 4'd1;
    end
  end

  // Next state, digits, prescaler and pulse. Clear wins over mag_on handling,
  // and mag_on handling wins over digit entry.
  always_comb begin
    state_nx = state;
    presc_nx = presc;
    mt_nx    = min_tens;
    mo_nx    = min_ones;
    st_nx    = sec_tens;
    so_nx    = sec_ones;
    pulse_nx = 1'b0;
    if (!clearn) begin
      state_nx = IDLE;
      presc_nx = '0;
      mt_nx    = 4'd0;
      mo_nx    = 4'd0;
      st_nx    = 4'd0;
      so_nx    = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mag_on) begin
            // Starting with an empty count is a protocol violation, so stay here.
            if (!timer_done) state_nx = COOK;
          end else if (digit_valid && (digit <= 4'd9)) begin
            mt_nx = min_ones;
            mo_nx = sec_tens;
            st_nx = sec_ones;
            so_nx = digit;
          end
        end
        COOK: begin
          presc_nx = tick ? '0 : presc + PW'(1);
          if (tick) begin
            mt_nx = mt_dec;
            mo_nx = mo_dec;
            st_nx = st_dec;
            so_nx = so_dec;
            if (dec_zero) begin
              pulse_nx = 1'b1;
              state_nx = IDLE;
              presc_nx = '0;
            end else if (!mag_on) begin
              state_nx = PAUSE;
            end
          end else if (!mag_on) begin
            state_nx = PAUSE;
          end
        end
        PAUSE: begin
          // The prescaler holds here, so a partial second carries over when cooking resumes.
          if (mag_on) state_nx = COOK;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Register stage with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      presc      <= '0;
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      presc      <= presc_nx;
      min_tens   <= mt_nx;
      min_ones   <= mo_nx;
      sec_tens   <= st_nx;
      sec_ones   <= so_nx;
      done_pulse <= pulse_nx;
    end
  end

endmodule

// File: tb/tb_cook_timer.sv
// Testbench for cook_timer. A reference model holds the count as a plain
// decimal number MMSS and tracks the cooking phase as elapsed cycles. Every
// cycle, all outputs are compared against this model. Directed checks cover
// the key points: entry, countdown, borrow, pause/resume, clear, the start
// guard and asynchronous reset.
module tb_cook_timer;

  localparam int CPS = 4;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       mag_on = 1'b0;
  logic       clearn = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done, done_pulse, cooking;
  logic [15:0] dsp;

  assign dsp = {min_tens, min_ones, sec_tens, sec_ones};

  cook_timer #(.CLKS_PER_SEC(CPS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mag_on     (mag_on),
    .clearn     (clearn),
    .digit_valid(digit_valid),
    .digit      (digit),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .timer_done (timer_done),
    .done_pulse (done_pulse),
    .cooking    (cooking)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_seen = 0;

  // Reference model: m_val is the count as decimal MMSS (for example 0130 is 1:30).
  // m_phase is the number of cycles elapsed within the current second.
  int m_val   = 0;
  int m_phase = 0;
  bit m_run   = 1'b0;
  bit m_hold  = 1'b0;
  bit m_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bcd_of(input int v);
    return 32'(((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  // One second less, with a minutes borrow that reloads 59 seconds.
  function automatic int sec_down(input int v);
    int m, s;
    m = v / 100;
    s = v % 100;
    if (s > 0) s = s - 1;
    else if (m > 0) begin m = m - 1; s = 59; end
    return m * 100 + s;
  endfunction

  task automatic model_reset();
    m_val = 0; m_phase = 0; m_run = 1'b0; m_hold = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step();
    m_pulse = 1'b0;
    if (!clearn) begin
      m_val = 0; m_phase = 0; m_run = 1'b0; m_hold = 1'b0;
    end else if (m_run) begin
      m_phase++;
      if (m_phase == CPS) begin
        m_phase = 0;
        m_val = sec_down(m_val);
        if (m_val == 0) begin
          m_pulse = 1'b1;
          m_run = 1'b0;
        end else if (!mag_on) begin
          m_run = 1'b0; m_hold = 1'b1;
        end
      end else if (!mag_on) begin
        m_run = 1'b0; m_hold = 1'b1;
      end
    end else if (m_hold) begin
      if (mag_on) begin m_run = 1'b1; m_hold = 1'b0; end
    end else begin
      if (mag_on) begin
        if (m_val != 0) m_run = 1'b1;
      end else if (digit_valid && digit <= 4'd9) begin
        m_val = (m_val * 10 + int'(digit)) % 10000;
      end
    end
  endtask

  // Scoreboard compare of every output against the model.
  task automatic compare_all();
    check("display", 32'(dsp), bcd_of(m_val));
    check("timer_done", 32'(timer_done), 32'(m_val == 0));
    check("done_pulse", 32'(done_pulse), 32'(m_pulse));
    check("cooking", 32'(cooking), 32'(m_run));
    if (done_pulse) pulse_seen++;
  endtask

  // Driver tasks. Inputs change just after the falling edge, and outputs are sampled on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1;
    digit = d;
    cycle();
    digit_valid = 1'b0;
  endtask

  task automatic clear();
    clearn = 1'b0;
    cycle();
    clearn = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dsp"}, 32'(dsp), 32'h0);
    check({tag, "_done"}, 32'(timer_done), 32'h1);
    check({tag, "_pulse"}, 32'(done_pulse), 32'h0);
    check({tag, "_cook"}, 32'(cooking), 32'h0);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_vals("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Entry: 1,2,3 gives 01:23. A digit above 9 is ignored.
    key(4'd1); key(4'd2); key(4'd3);
    check("entry_dsp", 32'(dsp), 32'h0123);
    check("entry_done", 32'(timer_done), 32'h0);
    key(4'd11);
    check("entry_bad_digit", 32'(dsp), 32'h0123);

    // Countdown from 0:02
    clear();
    key(4'd2);
    pulse_seen = 0;
    mag_on = 1'b1;
    cycle();
    check("cd_cooking", 32'(cooking), 32'h1);
    repeat (4) cycle();
    check("cd_tick1", 32'(dsp), 32'h0001);
    repeat (4) cycle();
    check("cd_zero", 32'(dsp), 32'h0000);
    check("cd_pulse", 32'(done_pulse), 32'h1);
    repeat (3) cycle();
    check("cd_pulse_once", 32'(pulse_seen), 32'd1);
    check("cd_idle", 32'(cooking), 32'h0);
    mag_on = 1'b0;
    cycle();

    // Borrow: 1:00 becomes 0:59, and 0:90 becomes 0:89
    clear();
    key(4'd1); key(4'd0); key(4'd0);
    mag_on = 1'b1;
    repeat (5) cycle();
    check("borrow_min", 32'(dsp), 32'h0059);
    mag_on = 1'b0;
    cycle();
    clear();
    key(4'd9); key(4'd0);
    mag_on = 1'b1;
    repeat (5) cycle();
    check("borrow_90", 32'(dsp), 32'h0089);
    mag_on = 1'b0;
    cycle();
    clear();

    // Pause/resume from 0:05
    key(4'd5);
    mag_on = 1'b1;
    repeat (7) cycle();
    mag_on = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 2) key(4'(i % 10));
      else cycle();
    end
    check("pause_hold", 32'(dsp), 32'h0004);
    check("pause_not_cook", 32'(cooking), 32'h0);
    mag_on = 1'b1;
    repeat (2) cycle();
    check("resume_tick", 32'(dsp), 32'h0003);

    // Clear mid-cook, with a digit strobed in the same cycle
    mag_on = 1'b0;
    cycle();
    clear();
    key(4'd3); key(4'd0);
    mag_on = 1'b1;
    repeat (6) cycle();
    clearn = 1'b0; digit_valid = 1'b1; digit = 4'd7;
    cycle();
    clearn = 1'b1; digit_valid = 1'b0;
    check("clear_dsp", 32'(dsp), 32'h0000);
    check("clear_done", 32'(timer_done), 32'h1);
    check("clear_pulse", 32'(done_pulse), 32'h0);

    // Start guard: mag_on with 00:00 must not start a count
    pulse_seen = 0;
    repeat (10) cycle();
    check("guard_cook", 32'(cooking), 32'h0);
    check("guard_pulse", 32'(pulse_seen), 32'd0);
    mag_on = 1'b0;
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      clearn = ($urandom_range(0, 24) != 0);
      digit_valid = ($urandom_range(0, 2) == 0);
      digit = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) mag_on = ~mag_on;
      cycle();
    end
    clearn = 1'b1; digit_valid = 1'b0; mag_on = 1'b0;
    cycle();

    // Asynchronous reset in the middle of a cook
    clear();
    key(4'd1); key(4'd5);
    mag_on = 1'b1;
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    mag_on = 1'b0;
    compare_all();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
